// File: rtl/pipeline_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipeline_fetch
// Brief    : Instruction-fetch stage of the five-stage MIPS pipeline.
//            Owns the PC, issues word reads on the instruction bus, and hands
//            each fetched word to decode behind a valid/ready handshake. A
//            one-entry skid register absorbs a word that returns while decode
//            is stalled. Redirects flush local state and restart fetch.
//            Optional macro FETCH_PERF_COUNTERS_EN adds the perf_fetched and
//            perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================

package pipeline_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        jump;
    } fetch_data_t;
endpackage

module pipeline_fetch
    import pipeline_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t dataF
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Bus address register: frozen while a request waits for addr_ok, so a
    // redirect can move pc without disturbing the outstanding request.
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        out_valid_q, out_valid_d;
    fetch_data_t out_data_q, out_data_d;
    fetch_data_t skid_q, skid_d;

    logic        w_consume;
    logic [31:0] w_redirect_pc;
    fetch_data_t w_word;

    assign w_consume     = out_valid_q & out_ready;
    // Masking keeps every redirect_pc bit in use while forcing word alignment.
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    assign w_word.pc          = pc_q;
    assign w_word.instruction = iresp_data;
    assign w_word.jump        = (iresp_data[31:26] == 6'b000010);

    assign ireq_valid = (state_q == S_REQ) & ~reset;
    assign ireq_addr  = addr_q;
    assign out_valid  = out_valid_q;
    assign dataF      = out_data_q;

    // Next-state, PC, drop, output-register and skid updates.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        skid_d      = skid_q;

        if (w_consume) begin
            out_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            out_valid_d = 1'b0;
            skid_d      = '0;
            pc_d        = w_redirect_pc;
            case (state_q)
                S_REQ: begin
                    // The request on the bus must run to completion; its
                    // response will be discarded.
                    drop_d  = 1'b1;
                    state_d = iresp_addr_ok ? S_WAIT : S_REQ;
                end
                S_WAIT: begin
                    if (iresp_data_ok) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (iresp_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iresp_data_ok) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            pc_d = pc_q + 32'd4;
                            if (!out_valid_q || out_ready) begin
                                out_data_d  = w_word;
                                out_valid_d = 1'b1;
                                state_d     = S_REQ;
                            end else begin
                                skid_d  = w_word;
                                state_d = S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        out_data_d  = skid_q;
                        out_valid_d = 1'b1;
                        skid_d      = '0;
                        state_d     = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end

        if ((state_q == S_REQ) && !iresp_addr_ok) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            skid_q      <= skid_d;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Handshake and decode-stall counters; redirects leave them running.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (w_consume) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (out_valid_q && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipeline_fetch
// Brief    : Scoreboard bench for pipeline_fetch. Stimulus queues expected
//            bus addresses and decode outputs; a bus model and an output
//            monitor pop and compare independently.
// Revision : 1.0 - initial release
// ============================================================================

module tb_pipeline_fetch;
    import pipeline_fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    fetch_data_t dataF;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    pipeline_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dataF          (dataF)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    fetch_data_t exp_out_q[$];

    int          budget    = 0;
    logic        hold_data = 1'b0;
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] ins, input logic j);
        fetch_data_t e;
        e.pc          = pc;
        e.instruction = ins;
        e.jump        = j;
        exp_out_q.push_back(e);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h0800_0010;
            32'hBFC0_0004: return 32'h2008_0005;
            32'hBFC0_0008: return 32'h0000_0020;
            32'hBFC0_000C: return 32'h0C00_0040;
            32'hBFC0_0010: return 32'h0BFF_FFFF;
            32'hBFC0_0014: return 32'h2009_0001;
            32'h0000_1000: return 32'h0800_0400;
            32'h0000_1004: return 32'h1000_FFFF;
            32'h0000_2000: return 32'h2010_0002;
            32'h0000_2004: return 32'h2011_0003;
            32'hFFFF_FFFC: return 32'h0800_0001;
            32'h0000_0000: return 32'h0000_0000;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Instruction-bus model: accepts up to 'budget' requests, returns data
    // the cycle after acceptance unless held back.
    initial begin
        logic [31:0] ea;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        forever begin
            @(posedge clk);
            #2;
            iresp_addr_ok = 1'b0;
            iresp_data_ok = 1'b0;
            if (pend && !hold_data) begin
                iresp_data_ok = 1'b1;
                iresp_data    = mem_word(pend_addr);
                pend          = 1'b0;
            end
            if (budget > 0 && ireq_valid && !pend) begin
                iresp_addr_ok = 1'b1;
                pend          = 1'b1;
                pend_addr     = ireq_addr;
                budget--;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ireq_addr: got unexpected request %h expected none", ireq_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("ireq_addr", ireq_addr, ea);
                end
            end
        end
    end

    // Output monitor: every decode handshake must match the next expected word.
    initial begin
        fetch_data_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dataF: got unexpected %h expected none", dataF);
                end else begin
                    e = exp_out_q.pop_front();
                    check("dataF", dataF, e);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ireq_valid", ireq_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_dataF", dataF, 65'd0);

        // Straight-line fetch with a zero-wait bus
        exp_addr_q.push_back(32'hBFC0_0000);
        exp_addr_q.push_back(32'hBFC0_0004);
        exp_addr_q.push_back(32'hBFC0_0008);
        push_out(32'hBFC0_0000, 32'h0800_0010, 1'b1);
        push_out(32'hBFC0_0004, 32'h2008_0005, 1'b0);
        push_out(32'hBFC0_0008, 32'h0000_0020, 1'b0);
        step(); reset = 1'b0; budget = 3;
        @(negedge clk);
        check("first_ireq_valid", ireq_valid, 1'b1);
        check("first_ireq_addr", ireq_addr, 32'hBFC0_0000);
        step();
        step(); @(negedge clk); check("lat_out_valid_c2", out_valid, 1'b1);
        step(); @(negedge clk); check("tp_out_valid_c3", out_valid, 1'b0);
        step(); @(negedge clk); check("tp_out_valid_c4", out_valid, 1'b1);
        check("tp_pc_c4", dataF.pc, 32'hBFC0_0004);
        step(); step(); step();

        // Decode stall for 5 cycles: skid parks the next word
        exp_addr_q.push_back(32'hBFC0_000C);
        exp_addr_q.push_back(32'hBFC0_0010);
        push_out(32'hBFC0_000C, 32'h0C00_0040, 1'b0);
        push_out(32'hBFC0_0010, 32'h0BFF_FFFF, 1'b1);
        step(); out_ready = 1'b0; budget = 2;
        step();
        step(); @(negedge clk);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_pc", dataF.pc, 32'hBFC0_000C);
        step();
        step(); @(negedge clk); check("hold_no_req", ireq_valid, 1'b0);
        step();
        step(); @(negedge clk);
        check("frozen_pc", dataF.pc, 32'hBFC0_000C);
        check("hold_no_req_late", ireq_valid, 1'b0);
        step(); out_ready = 1'b1;
        @(negedge clk); check("release_pc", dataF.pc, 32'hBFC0_000C);
        step(); @(negedge clk);
        check("skid_valid", out_valid, 1'b1);
        check("skid_pc", dataF.pc, 32'hBFC0_0010);
        step();
`ifdef FETCH_PERF_COUNTERS_EN
        @(negedge clk);
        check("perf_stall", perf_stall, 32'd5);
        check("perf_fetched", perf_fetched, 32'd5);
`endif

        // Redirect while waiting for data
        exp_addr_q.push_back(32'hBFC0_0014);
        step(); budget = 1; hold_data = 1'b1;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
        exp_addr_q.push_back(32'h0000_1000);
        exp_addr_q.push_back(32'h0000_1004);
        push_out(32'h0000_1000, 32'h0800_0400, 1'b1);
        push_out(32'h0000_1004, 32'h1000_FFFF, 1'b0);
        step(); redirect_valid = 1'b0; hold_data = 1'b0; budget = 2;
        @(negedge clk); check("redir_wait_out_valid", out_valid, 1'b0);
        step(); @(negedge clk);
        check("redir_wait_req", ireq_valid, 1'b1);
        check("redir_wait_addr", ireq_addr, 32'h0000_1000);
        repeat (5) step();

        // Redirect in the same cycle as data_ok
        exp_addr_q.push_back(32'h0000_1008);
        step(); budget = 1;
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        exp_addr_q.push_back(32'h0000_2000);
        exp_addr_q.push_back(32'h0000_2004);
        push_out(32'h0000_2000, 32'h2010_0002, 1'b0);
        push_out(32'h0000_2004, 32'h2011_0003, 1'b0);
        step(); redirect_valid = 1'b0; budget = 2;
        @(negedge clk);
        check("redir_dok_addr", ireq_addr, 32'h0000_2000);
        check("redir_dok_out_valid", out_valid, 1'b0);
        repeat (5) step();

        // Redirect while addr_ok is withheld; target wraps past 2^32
        step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk); check("held_addr_g0", ireq_addr, 32'h0000_2008);
        step(); redirect_valid = 1'b0;
        @(negedge clk); check("held_addr_g1", ireq_addr, 32'h0000_2008);
        step(); @(negedge clk);
        check("held_req_g2", ireq_valid, 1'b1);
        check("held_addr_g2", ireq_addr, 32'h0000_2008);
        exp_addr_q.push_back(32'h0000_2008);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        push_out(32'hFFFF_FFFC, 32'h0800_0001, 1'b1);
        push_out(32'h0000_0000, 32'h0000_0000, 1'b0);
        step(); budget = 3;
        step();
        step(); @(negedge clk); check("target_addr", ireq_addr, 32'hFFFF_FFFC);
        repeat (5) step();

        // Reset asserted while waiting for data; stray data_ok afterwards
        exp_addr_q.push_back(32'h0000_0004);
        step(); budget = 1; hold_data = 1'b1;
        step(); reset = 1'b1;
        step(); reset = 1'b0; hold_data = 1'b0;
        @(negedge clk);
        check("rst2_req", ireq_valid, 1'b1);
        check("rst2_addr", ireq_addr, 32'hBFC0_0000);
        check("rst2_out_valid", out_valid, 1'b0);
        step(); @(negedge clk);
        check("stray_out_valid", out_valid, 1'b0);
        check("stray_addr", ireq_addr, 32'hBFC0_0000);
`ifdef FETCH_PERF_COUNTERS_EN
        check("rst2_perf_fetched", perf_fetched, 32'd0);
        check("rst2_perf_stall", perf_stall, 32'd0);
`endif
        exp_addr_q.push_back(32'hBFC0_0000);
        push_out(32'hBFC0_0000, 32'h0800_0010, 1'b1);
        step(); budget = 1;
        repeat (6) step();

        @(negedge clk);
        check("addr_queue_empty", exp_addr_q.size(), 0);
        check("out_queue_empty", exp_out_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
